beat_timing_gen: RTL and testbench

- Instruction-beat sequencer for the hardwired CPU controller.
- Generates the one-hot machine beats W[3:1] that the control decoder consumes. Honours the decoder's SHORT/LONG/STOP requests.
- Runs a run/idle/halt state machine driven by the front-panel START key and the SW mode switches.
- Produces the ST0 phase flag used by console operations, plus a completed-instruction counter for debug.

---
 rtl/hdcpu_pkg.sv | 25 ++
 rtl/beat_timing_gen_start_edge.sv | 22 ++
 rtl/beat_timing_gen.sv | 124 ++++++++++++
 tb/tb_beat_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdcpu_pkg.sv
// Shared types and constants for the hardwired CPU controller.
package hdcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [2:0] W1 = 3'b001;
  localparam logic [2:0] W2 = 3'b010;
  localparam logic [2:0] W3 = 3'b100;

  localparam logic [2:0] MODE_RUN  = 3'b000;
  localparam logic [2:0] MODE_WMEM = 3'b001;
  localparam logic [2:0] MODE_RMEM = 3'b010;
  localparam logic [2:0] MODE_RREG = 3'b011;
  localparam logic [2:0] MODE_WREG = 3'b100;

  // Console modes are 001..100; undefined codes behave as program run.
  function automatic logic mode_is_console(input logic [2:0] sw);
    return (sw != MODE_RUN) && (sw <= MODE_WREG);
  endfunction

endpackage

// File: rtl/beat_timing_gen_start_edge.sv
// One-flop rising-edge detector for the front-panel START key.
module start_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic rise_c
);

  logic start_q;
  logic start_d;

  always_comb begin
    start_d = start;
    rise_c  = start & ~start_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= start_d;
  end

endmodule

// File: rtl/beat_timing_gen.sv
// Instruction-beat sequencer: one-hot W beats, run/idle/halt control,
// console phase flag ST0 and a completed-instruction counter.
module beat_timing_gen
  import hdcpu_pkg::*;
#(
  parameter int unsigned COUNT_W  = 8,
  parameter bit          AUTO_RUN = 1'b0
) (
  input  logic               T3,
  input  logic               CLR,
  input  logic               START,
  input  logic [2:0]         SW,
  input  logic               SHORT,
  input  logic               LONG,
  input  logic               STOP,
  output logic [2:0]         W,
  output logic               ST0,
  output logic               RUN,
  output logic [COUNT_W-1:0] CYC
);

  localparam state_t RST_STATE = AUTO_RUN ? ST_RUN : ST_IDLE;

  state_t               state_q, state_d;
  logic [2:0]           w_q, w_d;
  logic                 st0_q, st0_d;
  logic                 run_q, run_d;
  logic [COUNT_W-1:0]   cyc_q, cyc_d;
  logic [2:0]           sw_q, sw_d;
  logic                 start_rise_c;
  logic                 instr_end;

  start_edge u_start_edge (
    .clk    (T3),
    .rst_n  (CLR),
    .start  (START),
    .rise_c (start_rise_c)
  );

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    st0_d     = st0_q;
    cyc_d     = cyc_q;
    sw_d      = SW;
    instr_end = 1'b0;

    // A mode switch change aborts whatever is in progress.
    if (SW != sw_q) begin
      state_d = ST_IDLE;
      w_d     = W1;
      st0_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HALT: begin
          w_d = W1;
          if (start_rise_c && !STOP) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (STOP) begin
            state_d   = ST_HALT;
            w_d       = W1;
            instr_end = 1'b1;
          end else begin
            unique case (w_q)
              W1: begin
                if (SHORT) instr_end = 1'b1;
                else       w_d       = W2;
              end
              W2: begin
                if (LONG) begin
                  w_d = W3;
                end else begin
                  w_d       = W1;
                  instr_end = 1'b1;
                end
              end
              W3: begin
                w_d       = W1;
                instr_end = 1'b1;
              end
              default: w_d = W1;
            endcase
          end
        end
        default: begin
          state_d = ST_IDLE;
          w_d     = W1;
        end
      endcase
    end

    if (instr_end) begin
      cyc_d = cyc_q + COUNT_W'(1);
      if (mode_is_console(SW)) st0_d = 1'b1;
    end

    run_d = (state_d == ST_RUN);
  end

  always_ff @(posedge T3 or negedge CLR) begin
    if (!CLR) begin
      state_q <= RST_STATE;
      w_q     <= W1;
      st0_q   <= 1'b0;
      run_q   <= AUTO_RUN;
      cyc_q   <= '0;
      sw_q    <= MODE_RUN;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      st0_q   <= st0_d;
      run_q   <= run_d;
      cyc_q   <= cyc_d;
      sw_q    <= sw_d;
    end
  end

  assign W   = w_q;
  assign ST0 = st0_q;
  assign RUN = run_q;
  assign CYC = cyc_q;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Scoreboard bench for beat_timing_gen: a behavioural model queues the
// expected outputs for every edge, and each test task checks them.
module tb_beat_timing_gen;

  typedef struct packed {
    logic [2:0] w;
    logic       st0;
    logic       run;
    logic [7:0] cyc;
  } exp_t;

  logic       T3;
  logic       CLR;
  logic       START;
  logic [2:0] SW;
  logic       SHORT;
  logic       LONG;
  logic       STOP;
  logic [2:0] W;
  logic       ST0;
  logic       RUN;
  logic [7:0] CYC;

  logic       clr4;
  logic [2:0] W4;
  logic       ST04;
  logic       RUN4;
  logic [3:0] CYC4;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  // Reference model state
  int         m_state;  // 0 idle, 1 run, 2 halt
  int         m_beat;   // 1..3
  logic       m_st0;
  logic [7:0] m_cyc;
  logic       m_start_prev;
  logic [2:0] m_sw_prev;

  beat_timing_gen #(.COUNT_W(8), .AUTO_RUN(1'b0)) dut (
    .T3(T3), .CLR(CLR), .START(START), .SW(SW), .SHORT(SHORT),
    .LONG(LONG), .STOP(STOP), .W(W), .ST0(ST0), .RUN(RUN), .CYC(CYC)
  );

  beat_timing_gen #(.COUNT_W(4), .AUTO_RUN(1'b1)) dut4 (
    .T3(T3), .CLR(clr4), .START(1'b0), .SW(3'b000), .SHORT(1'b1),
    .LONG(1'b0), .STOP(1'b0), .W(W4), .ST0(ST04), .RUN(RUN4), .CYC(CYC4)
  );

  initial T3 = 1'b0;
  always #5 T3 = ~T3;

  task automatic model_reset();
    m_state = 0; m_beat = 1; m_st0 = 1'b0; m_cyc = 8'd0;
    m_start_prev = 1'b0; m_sw_prev = 3'b000;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.w   = 3'(1 << (m_beat - 1));
    e.st0 = m_st0;
    e.run = (m_state == 1);
    e.cyc = m_cyc;
    return e;
  endfunction

  task automatic model_edge();
    logic rise;
    logic ended;
    rise = START && !m_start_prev;
    ended = 1'b0;
    if (SW !== m_sw_prev) begin
      m_state = 0; m_beat = 1; m_st0 = 1'b0;
    end else if (m_state != 1) begin
      m_beat = 1;
      if (rise && !STOP) m_state = 1;
    end else if (STOP) begin
      m_state = 2; m_beat = 1; ended = 1'b1;
    end else begin
      case (m_beat)
        1: if (SHORT) ended = 1'b1; else m_beat = 2;
        2: if (LONG) m_beat = 3; else begin m_beat = 1; ended = 1'b1; end
        default: begin m_beat = 1; ended = 1'b1; end
      endcase
    end
    m_start_prev = START;
    m_sw_prev = SW;
    if (ended) begin
      m_cyc = m_cyc + 8'd1;
      if (SW >= 3'd1 && SW <= 3'd4) m_st0 = 1'b1;
    end
  endtask

  // Stimulus word: {start, sw[2:0], short, long, stop}
  task automatic drive(input logic [6:0] s);
    START = s[6]; SW = s[5:3]; SHORT = s[2]; LONG = s[1]; STOP = s[0];
    model_edge();
    exp_q.push_back(model_out());
    @(posedge T3);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    CLR = 1'b0; clr4 = 1'b0;
    START = 1'b0; SW = 3'b000; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    repeat (2) @(posedge T3);
    #1;
    e = exp_q.pop_front();
    got = {W, ST0, RUN, CYC};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", got, e);
    end
    n_checks++;
    if ({W4, ST04, RUN4, CYC4} !== {3'b001, 1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_autorun: got W=%b ST0=%b RUN=%b CYC=%0d expected W=001 ST0=0 RUN=1 CYC=0",
               W4, ST04, RUN4, CYC4);
    end
    CLR = 1'b1;
  endtask

  task automatic test_basic_run();
    logic [6:0] stim [6] = '{7'b0_000_000, 7'b1_000_000, 7'b0_000_000,
                             7'b0_000_000, 7'b0_000_000, 7'b0_000_000};
    exp_t e, got;
    foreach (stim[i]) begin
      drive(stim[i]);
      e = exp_q.pop_front();
      got = {W, ST0, RUN, CYC};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL basic_run[%0d]: got W=%b ST0=%b RUN=%b CYC=%0d expected W=%b ST0=%b RUN=%b CYC=%0d",
                 i, got.w, got.st0, got.run, got.cyc, e.w, e.st0, e.run, e.cyc);
      end
    end
  endtask

  task automatic test_short_long();
    logic [6:0] stim [8] = '{7'b0_000_100, 7'b0_000_100, 7'b0_000_100,
                             7'b0_000_000, 7'b0_000_010, 7'b0_000_010,
                             7'b0_000_110, 7'b0_000_110};
    exp_t e, got;
    foreach (stim[i]) begin
      drive(stim[i]);
      e = exp_q.pop_front();
      got = {W, ST0, RUN, CYC};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL short_long[%0d]: got W=%b ST0=%b RUN=%b CYC=%0d expected W=%b ST0=%b RUN=%b CYC=%0d",
                 i, got.w, got.st0, got.run, got.cyc, e.w, e.st0, e.run, e.cyc);
      end
    end
  endtask

  task automatic test_stop_halt();
    // STOP+START in W2, resume, STOP again, START blocked by STOP in HALT
    logic [6:0] stim [11] = '{7'b0_000_000, 7'b1_000_001, 7'b0_000_000,
                              7'b1_000_000, 7'b0_000_000, 7'b0_000_001,
                              7'b1_000_001, 7'b0_000_000, 7'b1_000_000,
                              7'b0_000_000, 7'b0_000_000};
    exp_t e, got;
    foreach (stim[i]) begin
      drive(stim[i]);
      e = exp_q.pop_front();
      got = {W, ST0, RUN, CYC};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL stop_halt[%0d]: got W=%b ST0=%b RUN=%b CYC=%0d expected W=%b ST0=%b RUN=%b CYC=%0d",
                 i, got.w, got.st0, got.run, got.cyc, e.w, e.st0, e.run, e.cyc);
      end
    end
  endtask

  task automatic test_st0_sw_change();
    // Mode 010 run, switch to 011 mid-W2, then undefined mode 101 run
    logic [6:0] stim [15] = '{7'b0_010_000, 7'b1_010_000, 7'b0_010_000,
                              7'b0_010_000, 7'b0_010_000, 7'b0_010_000,
                              7'b0_010_000, 7'b0_011_000, 7'b0_011_000,
                              7'b0_101_000, 7'b1_101_000, 7'b0_101_000,
                              7'b0_101_000, 7'b0_101_100, 7'b0_000_000};
    exp_t e, got;
    foreach (stim[i]) begin
      drive(stim[i]);
      e = exp_q.pop_front();
      got = {W, ST0, RUN, CYC};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL st0_sw[%0d]: got W=%b ST0=%b RUN=%b CYC=%0d expected W=%b ST0=%b RUN=%b CYC=%0d",
                 i, got.w, got.st0, got.run, got.cyc, e.w, e.st0, e.run, e.cyc);
      end
    end
  endtask

  task automatic test_async_clr();
    logic [6:0] pre  [2] = '{7'b1_000_000, 7'b0_000_000};
    logic [6:0] post [3] = '{7'b1_000_000, 7'b0_000_000, 7'b0_000_000};
    exp_t e, got;
    foreach (pre[i]) begin
      drive(pre[i]);
      e = exp_q.pop_front();
      got = {W, ST0, RUN, CYC};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL clr_pre[%0d]: got %h expected %h", i, got, e);
      end
    end
    // Now in W2: pulse CLR between clock edges
    #2 CLR = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    got = {W, ST0, RUN, CYC};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL clr_async: got W=%b ST0=%b RUN=%b CYC=%0d expected W=%b ST0=%b RUN=%b CYC=%0d",
               got.w, got.st0, got.run, got.cyc, e.w, e.st0, e.run, e.cyc);
    end
    #1 CLR = 1'b1;
    START = 1'b0;
    foreach (post[i]) begin
      drive(post[i]);
      e = exp_q.pop_front();
      got = {W, ST0, RUN, CYC};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL clr_post[%0d]: got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e, got;
    logic [3:0] cnt;
    cnt = 4'd0;
    clr4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cnt = cnt + 4'd1;
      exp_q.push_back('{w: 3'b001, st0: 1'b0, run: 1'b1, cyc: {4'd0, cnt}});
      @(posedge T3);
      #1;
      e = exp_q.pop_front();
      got = {W4, ST04, RUN4, 4'd0, CYC4};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL wrap4[%0d]: got W=%b RUN=%b CYC=%0d expected W=%b RUN=%b CYC=%0d",
                 i, got.w, got.run, got.cyc, e.w, e.run, e.cyc);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_run();
    test_short_long();
    test_stop_halt();
    test_st0_sw_change();
    test_async_clr();
    test_wrap();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
